// File: rtl/cdc_handshake_tx.sv
// Source end of a 4-phase req/ack handshake. It carries one WIDTH-bit word out of the clk domain.
// The asynchronous tx_ack is resynchronised through a SYNC_STAGES flop chain before the FSM uses it.
module cdc_handshake_tx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    input  logic             tx_ack,
    output logic             busy,
    output logic             timeout_err
);

    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        REQ     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] ack_sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [WIDTH-1:0]       tx_data_reg;
    logic                   tx_req_reg;
    logic                   timeout_err_reg;
    logic                   ack_s;
    logic                   expired;
    logic                   cnt_hold;

    assign ack_s    = ack_sync_reg[SYNC_STAGES-1];
    assign expired  = (ACK_TIMEOUT != 0) && (cnt_reg == CNT_LAST);
    // With the timeout disabled the counter still must not wrap, so it parks at all-ones.
    assign cnt_hold = expired || (cnt_reg == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            ack_sync_reg    <= '0;
            cnt_reg         <= '0;
            tx_data_reg     <= '0;
            tx_req_reg      <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            ack_sync_reg    <= {ack_sync_reg[SYNC_STAGES-2:0], tx_ack};
            timeout_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (in_valid) begin
                        tx_data_reg <= in_data;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    tx_req_reg <= 1'b1;
                    cnt_reg    <= '0;
                    state_reg  <= REQ;
                end
                REQ: begin
                    // An ack arriving on the expiry cycle takes priority over the timeout.
                    if (ack_s) begin
                        tx_req_reg <= 1'b0;
                        cnt_reg    <= '0;
                        state_reg  <= RELEASE;
                    end else if (expired) begin
                        timeout_err_reg <= 1'b1;
                        tx_req_reg      <= 1'b0;
                        cnt_reg         <= '0;
                        state_reg       <= RELEASE;
                    end else if (!cnt_hold) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        state_reg <= IDLE;
                    end else if (expired) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else if (!cnt_hold) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    tx_req_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign busy        = (state_reg != IDLE);
    assign tx_data     = tx_data_reg;
    assign tx_req      = tx_req_reg;
    assign timeout_err = timeout_err_reg;

endmodule
